decode_stage_pipe: RTL and testbench

- Parametrised successor to the current decode stage of the RISC-V integer pipeline; sits between fetch and execute.
- Registers decoded operands, immediate and control fields into the ID/EX boundary.
- Adds the following, none of which the current stage has:
  - valid/ready handshake on both sides, plus flush;
  - write-through register-file bypass;
  - load-use hazard stall;
  - refresh of operands held during a stall;
  - full I/S/B/U/J immediate decode and an illegal-opcode flag.

---
 rtl/riscv_pkg.sv | 43 ++++
 rtl/decode_stage_pipe_if.sv | 52 +++++
 rtl/reg_file_bypass.sv | 58 +++++
 rtl/decode_stage_pipe.sv | 149 ++++++++++++++
 tb/tb_decode_stage_pipe.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: opcode constants, immediate formats
// and the opcode-to-immediate-format lookup used by the decode stage.
package riscv_pkg;

   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] OP     = 7'b0110011;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_type_t;

   // Immediate format carried by an opcode; R-type and unknown opcodes have none.
   function automatic imm_type_t imm_type_of(input logic [6:0] opcode);
      imm_type_t t;
      case (opcode)
         OP_IMM, LOAD, JALR: t = IMM_I;
         STORE:              t = IMM_S;
         BRANCH:             t = IMM_B;
         LUI, AUIPC:         t = IMM_U;
         JAL:                t = IMM_J;
         default:            t = IMM_NONE;
      endcase
      return t;
   endfunction

   // An opcode is recognised if it has an immediate format or is register-register.
   function automatic logic opcode_legal(input logic [6:0] opcode);
      return (imm_type_of(opcode) != IMM_NONE) || (opcode == OP);
   endfunction

endpackage

// File: rtl/decode_stage_pipe_if.sv
// Bundle of the fetch-side, writeback, execute-hazard and ID/EX signals of
// the decode stage. The master drives the stage, the slave is the stage.
interface decode_stage_pipe_if #(
   parameter int XLEN = 32,
   parameter int RAW  = 5
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;

   logic            wb_we;
   logic [RAW-1:0]  wb_rd;
   logic [XLEN-1:0] wb_data;

   logic            ex_is_load;
   logic [RAW-1:0]  ex_rd;

   logic            flush;

   logic            out_valid;
   logic            out_ready;
   logic [31:0]     out_instr;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_a;
   logic [XLEN-1:0] out_b;
   logic [XLEN-1:0] out_imm;
   logic [2:0]      out_imm_type;
   logic [RAW-1:0]  out_rs1;
   logic [RAW-1:0]  out_rs2;
   logic [RAW-1:0]  out_rd;
   logic            out_illegal;

   modport master (
      output in_valid, in_instr, in_pc,
      output wb_we, wb_rd, wb_data,
      output ex_is_load, ex_rd, flush, out_ready,
      input  in_ready,
      input  out_valid, out_instr, out_pc, out_a, out_b, out_imm,
      input  out_imm_type, out_rs1, out_rs2, out_rd, out_illegal
   );

   modport slave (
      input  in_valid, in_instr, in_pc,
      input  wb_we, wb_rd, wb_data,
      input  ex_is_load, ex_rd, flush, out_ready,
      output in_ready,
      output out_valid, out_instr, out_pc, out_a, out_b, out_imm,
      output out_imm_type, out_rs1, out_rs2, out_rd, out_illegal
   );

endinterface

// File: rtl/reg_file_bypass.sv
// Architectural register file: two combinational read ports, one write
// port, x0 hard-wired to zero, optional same-cycle write-through forwarding.
module reg_file_bypass #(
   parameter int XLEN      = 32,
   parameter int NREG      = 32,
   parameter int RAW       = 5,
   parameter int BYPASS_EN = 1
) (
   input  logic            clk2,
   input  logic            rst,
   input  logic            we,
   input  logic [RAW-1:0]  wa,
   input  logic [XLEN-1:0] wd,
   input  logic [RAW-1:0]  ra1,
   output logic [XLEN-1:0] rd1,
   input  logic [RAW-1:0]  ra2,
   output logic [XLEN-1:0] rd2
);

   logic [XLEN-1:0] mem [NREG];

   // x0 and addresses beyond NREG read as zero; a matching write can be forwarded.
   function automatic logic [XLEN-1:0] read_port(
      input logic [RAW-1:0]  ra,
      input logic            w_en,
      input logic [RAW-1:0]  w_addr,
      input logic [XLEN-1:0] w_data,
      input logic [XLEN-1:0] stored
   );
      logic [XLEN-1:0] v;
      v = '0;
      if (ra != '0 && int'(ra) < NREG) begin
         v = stored;
         if (BYPASS_EN != 0 && w_en && w_addr == ra) begin
            v = w_data;
         end
      end
      return v;
   endfunction

   // Writes land on the clock edge; x0 is never written so it stays zero.
   always_ff @(posedge clk2 or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) begin
            mem[i] <= '0;
         end
      end else if (we && wa != '0 && int'(wa) < NREG) begin
         mem[wa] <= wd;
      end
   end

   // Both read ports see the stored value, or the writeback data when forwarding.
   always_comb begin
      rd1 = read_port(ra1, we, wa, wd, (int'(ra1) < NREG) ? mem[ra1] : '0);
      rd2 = read_port(ra2, we, wa, wd, (int'(ra2) < NREG) ? mem[ra2] : '0);
   end

endmodule

// File: rtl/decode_stage_pipe.sv
// RISC-V integer decode stage: reads operands, builds the immediate and
// registers everything into the ID/EX boundary with valid/ready flow
// control, flush, load-use stalling and refresh of operands held in a stall.
module decode_stage_pipe
   import riscv_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int NREG      = 32,
   parameter int RAW       = 5,
   parameter int BYPASS_EN = 1
) (
   input logic                clk2,
   input logic                rst,
   decode_stage_pipe_if.slave bus
);

   logic [6:0]      opcode;
   logic [RAW-1:0]  rs1;
   logic [RAW-1:0]  rs2;
   logic [RAW-1:0]  rd;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   imm_type_t       imm_type;
   logic            is_r;
   logic            illegal;
   logic            uses_rs1;
   logic            uses_rs2;
   logic            hazard;
   logic            advance;
   logic [31:0]     imm32;
   logic [XLEN-1:0] imm_ext;

   logic            valid_q;
   logic [31:0]     instr_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] a_q;
   logic [XLEN-1:0] b_q;
   logic [XLEN-1:0] imm_q;
   imm_type_t       imm_type_q;
   logic [RAW-1:0]  rs1_q;
   logic [RAW-1:0]  rs2_q;
   logic [RAW-1:0]  rd_q;
   logic            illegal_q;

   assign opcode   = bus.in_instr[6:0];
   assign rs1      = RAW'(bus.in_instr[19:15]);
   assign rs2      = RAW'(bus.in_instr[24:20]);
   assign rd       = RAW'(bus.in_instr[11:7]);
   assign imm_type = imm_type_of(opcode);
   assign is_r     = (opcode == OP);
   assign illegal  = !opcode_legal(opcode);
   assign uses_rs1 = is_r || imm_type == IMM_I || imm_type == IMM_S || imm_type == IMM_B;
   assign uses_rs2 = is_r || imm_type == IMM_S || imm_type == IMM_B;

   reg_file_bypass #(
      .XLEN      (XLEN),
      .NREG      (NREG),
      .RAW       (RAW),
      .BYPASS_EN (BYPASS_EN)
   ) u_reg_file (
      .clk2 (clk2),
      .rst  (rst),
      .we   (bus.wb_we),
      .wa   (bus.wb_rd),
      .wd   (bus.wb_data),
      .ra1  (rs1),
      .rd1  (rs1_data),
      .ra2  (rs2),
      .rd2  (rs2_data)
   );

   // Assemble the 32-bit immediate for the decoded format; B and J keep bit 0 clear.
   always_comb begin
      imm32 = '0;
      case (imm_type)
         IMM_I: imm32 = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
         IMM_S: imm32 = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
         IMM_B: imm32 = {{19{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[7],
                         bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
         IMM_U: imm32 = {bus.in_instr[31:12], 12'b0};
         IMM_J: imm32 = {{11{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[19:12],
                         bus.in_instr[20], bus.in_instr[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   assign imm_ext = XLEN'($signed(imm32));

   assign hazard  = bus.in_valid && bus.ex_is_load && (bus.ex_rd != '0) &&
                    ((uses_rs1 && bus.ex_rd == rs1) || (uses_rs2 && bus.ex_rd == rs2));
   assign advance = !valid_q || bus.out_ready;

   assign bus.in_ready = bus.flush || (advance && !hazard);

   // ID/EX register: flush beats a bubble beats a load; a stalled entry only has its operands refreshed.
   always_ff @(posedge clk2 or negedge rst) begin
      if (!rst) begin
         valid_q    <= 1'b0;
         instr_q    <= '0;
         pc_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         imm_q      <= '0;
         imm_type_q <= IMM_NONE;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         illegal_q  <= 1'b0;
      end else if (bus.flush) begin
         valid_q <= 1'b0;
      end else if (advance && hazard) begin
         valid_q <= 1'b0;
      end else if (advance && bus.in_valid) begin
         valid_q    <= 1'b1;
         instr_q    <= bus.in_instr;
         pc_q       <= bus.in_pc;
         a_q        <= rs1_data;
         b_q        <= rs2_data;
         imm_q      <= imm_ext;
         imm_type_q <= imm_type;
         rs1_q      <= rs1;
         rs2_q      <= rs2;
         rd_q       <= rd;
         illegal_q  <= illegal;
      end else if (advance) begin
         valid_q <= 1'b0;
      end else begin
         if (bus.wb_we && bus.wb_rd != '0 && bus.wb_rd == rs1_q) begin
            a_q <= bus.wb_data;
         end
         if (bus.wb_we && bus.wb_rd != '0 && bus.wb_rd == rs2_q) begin
            b_q <= bus.wb_data;
         end
      end
   end

   assign bus.out_valid    = valid_q;
   assign bus.out_instr    = instr_q;
   assign bus.out_pc       = pc_q;
   assign bus.out_a        = a_q;
   assign bus.out_b        = b_q;
   assign bus.out_imm      = imm_q;
   assign bus.out_imm_type = imm_type_q;
   assign bus.out_rs1      = rs1_q;
   assign bus.out_rs2      = rs2_q;
   assign bus.out_rd       = rd_q;
   assign bus.out_illegal  = illegal_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Self-checking bench for decode_stage_pipe: directed scenarios followed by
// random traffic, all compared against a behavioural model of the stage.
module tb_decode_stage_pipe;

   localparam int XLEN      = 32;
   localparam int NREG      = 32;
   localparam int RAW       = 5;
   localparam int BYPASS_EN = 1;

   logic clk2 = 1'b0;
   logic rst;

   decode_stage_pipe_if #(.XLEN(XLEN), .RAW(RAW)) bus ();

   decode_stage_pipe #(
      .XLEN      (XLEN),
      .NREG      (NREG),
      .RAW       (RAW),
      .BYPASS_EN (BYPASS_EN)
   ) dut (
      .clk2 (clk2),
      .rst  (rst),
      .bus  (bus)
   );

   always #5 clk2 = ~clk2;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] m_rf [32];
   logic        exp_valid;
   logic [31:0] exp_instr, exp_pc, exp_a, exp_b, exp_imm;
   int          exp_type, exp_rs1, exp_rs2, exp_rd;
   logic        exp_ill;
   logic        exp_in_ready;
   logic        last_in_ready;

   task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
      end
   endtask

   function automatic int sx(input int v, input int bits);
      if (v >= (1 << (bits - 1))) return v - (1 << bits);
      return v;
   endfunction

   function automatic logic [31:0] model_read(input int r);
      if (r == 0) return 32'h0;
      if (BYPASS_EN != 0 && bus.wb_we && int'(bus.wb_rd) == r) return bus.wb_data;
      return m_rf[r];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
      exp_valid = 0; exp_instr = 0; exp_pc = 0; exp_a = 0; exp_b = 0; exp_imm = 0;
      exp_type = 0; exp_rs1 = 0; exp_rs2 = 0; exp_rd = 0; exp_ill = 0;
   endtask

   // Advances the model by one clock using the inputs currently driven.
   task automatic model_cycle();
      logic [31:0] ins;
      logic [6:0]  op;
      int t, r1, r2, ex;
      logic is_r, ill, use1, use2, hz, adv;
      logic [31:0] imm;
      ins = bus.in_instr;
      op  = ins[6:0];
      case (op)
         7'h13, 7'h03, 7'h67: t = 1;
         7'h23:               t = 2;
         7'h63:               t = 3;
         7'h37, 7'h17:        t = 4;
         7'h6F:               t = 5;
         default:             t = 0;
      endcase
      is_r = (op == 7'h33);
      ill  = (t == 0) && !is_r;
      case (t)
         1: imm = 32'(sx(int'(ins[31:20]), 12));
         2: imm = 32'(sx(int'(ins[31:25]) * 32 + int'(ins[11:7]), 12));
         3: imm = 32'(sx(int'(ins[31]) * 4096 + int'(ins[7]) * 2048 +
                         int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2, 13));
         4: imm = {12'b0, ins[31:12]} * 32'd4096;
         5: imm = 32'(sx(int'(ins[31]) * 1048576 + int'(ins[19:12]) * 4096 +
                         int'(ins[20]) * 2048 + int'(ins[30:21]) * 2, 21));
         default: imm = 32'h0;
      endcase
      r1   = int'(ins[19:15]);
      r2   = int'(ins[24:20]);
      ex   = int'(bus.ex_rd);
      use1 = is_r || (t >= 1 && t <= 3);
      use2 = is_r || t == 2 || t == 3;
      hz   = bus.in_valid && bus.ex_is_load && ex != 0 &&
             ((use1 && ex == r1) || (use2 && ex == r2));
      adv  = !exp_valid || bus.out_ready;
      exp_in_ready = bus.flush || (adv && !hz);
      if (bus.flush || (adv && hz) || (adv && !bus.in_valid)) begin
         exp_valid = 0;
      end else if (adv) begin
         exp_valid = 1; exp_instr = ins; exp_pc = bus.in_pc;
         exp_a = model_read(r1); exp_b = model_read(r2);
         exp_imm = imm; exp_type = t; exp_rs1 = r1; exp_rs2 = r2;
         exp_rd = int'(ins[11:7]); exp_ill = ill;
      end else begin
         if (bus.wb_we && bus.wb_rd != 0 && int'(bus.wb_rd) == exp_rs1) exp_a = bus.wb_data;
         if (bus.wb_we && bus.wb_rd != 0 && int'(bus.wb_rd) == exp_rs2) exp_b = bus.wb_data;
      end
      if (bus.wb_we && bus.wb_rd != 0) m_rf[bus.wb_rd] = bus.wb_data;
   endtask

   task automatic compare_outputs(input logic all_fields);
      check_output("out_valid", bus.out_valid, exp_valid);
      if (exp_valid || all_fields) begin
         check_output("out_instr", bus.out_instr, exp_instr);
         check_output("out_pc", bus.out_pc, exp_pc);
         check_output("out_a", bus.out_a, exp_a);
         check_output("out_b", bus.out_b, exp_b);
         check_output("out_imm", bus.out_imm, exp_imm);
         check_output("out_imm_type", 32'(bus.out_imm_type), 32'(exp_type));
         check_output("out_rs1", 32'(bus.out_rs1), 32'(exp_rs1));
         check_output("out_rs2", 32'(bus.out_rs2), 32'(exp_rs2));
         check_output("out_rd", 32'(bus.out_rd), 32'(exp_rd));
         check_output("out_illegal", 32'(bus.out_illegal), 32'(exp_ill));
      end
   endtask

   task automatic apply_stimulus(
      input logic iv, input logic [31:0] instr, input logic [31:0] pc,
      input logic we, input logic [4:0] wrd, input logic [31:0] wdat,
      input logic exl, input logic [4:0] exrd, input logic fl, input logic ordy
   );
      @(negedge clk2);
      bus.in_valid = iv; bus.in_instr = instr; bus.in_pc = pc;
      bus.wb_we = we; bus.wb_rd = wrd; bus.wb_data = wdat;
      bus.ex_is_load = exl; bus.ex_rd = exrd; bus.flush = fl; bus.out_ready = ordy;
      #1;
      model_cycle();
      last_in_ready = bus.in_ready;
      check_output("in_ready", 32'(bus.in_ready), 32'(exp_in_ready));
      @(posedge clk2);
      #1;
      compare_outputs(1'b0);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0]  ops [9];
      logic [31:0] w;
      int k;
      ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
      w = $urandom;
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
      k = $urandom_range(0, 9);
      if (k < 9) w[6:0] = ops[k];
      return w;
   endfunction

   initial begin
      rst = 1'b1;
      bus.in_valid = 0; bus.in_instr = 0; bus.in_pc = 0;
      bus.wb_we = 0; bus.wb_rd = 0; bus.wb_data = 0;
      bus.ex_is_load = 0; bus.ex_rd = 0; bus.flush = 0; bus.out_ready = 1;
      #1 rst = 1'b0;
      #2;
      model_reset();
      compare_outputs(1'b1);
      @(negedge clk2);
      rst = 1'b1;

      $display("[TB] reset and first decode");
      apply_stimulus(0, 0, 0, 1, 5, 32'h1234, 0, 0, 0, 1);
      apply_stimulus(1, 32'hFFF28093, 32'h100, 0, 0, 0, 0, 0, 0, 1);
      check_output("addi_valid", 32'(bus.out_valid), 32'h1);
      check_output("addi_a", bus.out_a, 32'h1234);
      check_output("addi_imm", bus.out_imm, 32'hFFFFFFFF);
      check_output("addi_type", 32'(bus.out_imm_type), 32'h1);

      $display("[TB] writeback bypass");
      apply_stimulus(1, 32'h00018233, 32'h104, 1, 3, 32'hDEADBEEF, 0, 0, 0, 1);
      check_output("bypass_a", bus.out_a, 32'hDEADBEEF);

      $display("[TB] load-use stall");
      apply_stimulus(1, 32'h00712423, 32'h108, 0, 0, 0, 1, 7, 0, 1);
      check_output("lu_in_ready", 32'(last_in_ready), 32'h0);
      check_output("lu_bubble", 32'(bus.out_valid), 32'h0);
      apply_stimulus(1, 32'h00712423, 32'h108, 0, 0, 0, 0, 0, 0, 1);
      check_output("lu_accept", 32'(last_in_ready), 32'h1);
      check_output("lu_imm", bus.out_imm, 32'h8);
      check_output("lu_type", 32'(bus.out_imm_type), 32'h2);

      $display("[TB] held operand refresh");
      apply_stimulus(0, 0, 0, 1, 6, 32'h66, 0, 0, 0, 1);
      apply_stimulus(1, 32'h008304B3, 32'h10C, 0, 0, 0, 0, 0, 0, 1);
      apply_stimulus(0, 0, 0, 1, 8, 32'h55, 0, 0, 0, 0);
      check_output("refresh_b", bus.out_b, 32'h55);
      check_output("refresh_a", bus.out_a, 32'h66);
      check_output("refresh_rd", 32'(bus.out_rd), 32'd9);
      apply_stimulus(0, 0, 0, 1, 0, 32'hFFFF, 0, 0, 0, 0);
      check_output("x0_a", bus.out_a, 32'h66);
      check_output("x0_b", bus.out_b, 32'h55);

      $display("[TB] immediate formats");
      apply_stimulus(1, 32'hFE000EE3, 32'h110, 0, 0, 0, 0, 0, 0, 1);
      check_output("beq_imm", bus.out_imm, 32'hFFFFFFFC);
      check_output("beq_type", 32'(bus.out_imm_type), 32'h3);
      apply_stimulus(1, 32'hABCDE0B7, 32'h114, 0, 0, 0, 0, 0, 0, 1);
      check_output("lui_imm", bus.out_imm, 32'hABCDE000);
      check_output("lui_type", 32'(bus.out_imm_type), 32'h4);
      apply_stimulus(1, 32'h0010006F, 32'h118, 0, 0, 0, 0, 0, 0, 1);
      check_output("jal_imm", bus.out_imm, 32'h00000800);
      check_output("jal_type", 32'(bus.out_imm_type), 32'h5);
      apply_stimulus(1, 32'h0000007F, 32'h11C, 0, 0, 0, 0, 0, 0, 1);
      check_output("ill_flag", 32'(bus.out_illegal), 32'h1);
      check_output("ill_imm", bus.out_imm, 32'h0);

      $display("[TB] flush");
      apply_stimulus(1, 32'hFFF28093, 32'h120, 0, 0, 0, 0, 0, 0, 1);
      apply_stimulus(1, 32'hABCDE0B7, 32'h124, 0, 0, 0, 0, 0, 1, 0);
      check_output("flush_in_ready", 32'(last_in_ready), 32'h1);
      check_output("flush_valid", 32'(bus.out_valid), 32'h0);

      $display("[TB] asynchronous reset during stall");
      apply_stimulus(1, 32'hFFF28093, 32'h128, 0, 0, 0, 0, 0, 0, 1);
      apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk2);
      #2 rst = 1'b0;
      #1;
      model_reset();
      compare_outputs(1'b1);
      @(negedge clk2);
      rst = 1'b1;
      apply_stimulus(1, 32'h00018233, 32'h12C, 0, 0, 0, 0, 0, 0, 1);
      check_output("rf_cleared", bus.out_a, 32'h0);

      $display("[TB] random traffic");
      repeat (600) begin
         apply_stimulus(
            logic'($urandom_range(0, 3) != 0), rand_instr(), $urandom,
            logic'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            logic'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
            logic'($urandom_range(0, 19) == 0), logic'($urandom_range(0, 9) < 7));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
